// File: rtl/rsa_decoder.sv
// RSA decryption m = c^d mod n by right-to-left square-and-multiply over an
// interleaved shift-add modular multiplier; fixed latency of 1 + W + 2*W^2 cycles.
module rsa_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cipher,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n_mod,
    output logic [WIDTH-1:0] plain,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // state | meaning
    // IDLE  | waiting for start, outputs held
    // RED   | base := cipher mod n (cipher as multiplier against 1)
    // MUL   | result * base, committed only when d_key[bit] is set
    // SQR   | base := base * base
    // DONE  | one-cycle completion pulse
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RED  = 3'd1;
    localparam logic [2:0] ST_MUL  = 3'd2;
    localparam logic [2:0] ST_SQR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_cipher;
    logic [WIDTH-1:0] r_dkey;
    logic [WIDTH-1:0] r_nmod;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_acc;
    logic [SW-1:0]    r_step;
    logic [SW-1:0]    r_bit;
    logic [WIDTH-1:0] r_plain;
    logic             r_err;

    logic [WIDTH-1:0] w_mult;
    logic [WIDTH-1:0] w_addend;
    logic             w_mbit;
    logic [WIDTH:0]   w_nx;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH:0]   w_dbl_red;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_prod;

    // RED multiplies 1 by the cipher so the addend is always < n, even when c >= n
    always_comb begin
        w_mult   = r_cipher;
        w_addend = WIDTH'(1);
        case (r_state)
            ST_MUL: begin
                w_mult   = r_result;
                w_addend = r_base;
            end
            ST_SQR: begin
                w_mult   = r_base;
                w_addend = r_base;
            end
            default: ;
        endcase
    end

    assign w_mbit    = w_mult[r_step];
    assign w_nx      = {1'b0, r_nmod};
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dbl_red = (w_dbl >= w_nx) ? (w_dbl - w_nx) : w_dbl;
    assign w_sum     = w_dbl_red + (w_mbit ? {1'b0, w_addend} : {(WIDTH+1){1'b0}});
    assign w_prod    = (w_sum >= w_nx) ? WIDTH'(w_sum - w_nx) : w_sum[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cipher <= '0;
            r_dkey   <= '0;
            r_nmod   <= '0;
            r_result <= '0;
            r_base   <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_bit    <= '0;
            r_plain  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cipher <= cipher;
                        r_dkey   <= d_key;
                        r_nmod   <= n_mod;
                        r_acc    <= '0;
                        r_step   <= LAST;
                        r_bit    <= '0;
                        if (n_mod < WIDTH'(2)) begin
                            r_err   <= 1'b1;
                            r_plain <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_err    <= 1'b0;
                            r_result <= WIDTH'(1);
                            r_state  <= ST_RED;
                        end
                    end
                end
                ST_RED, ST_MUL, ST_SQR: begin
                    r_acc <= w_prod;
                    if (r_step != '0) begin
                        r_step <= r_step - 1'b1;
                    end else begin
                        r_acc  <= '0;
                        r_step <= LAST;
                        if (r_state == ST_RED) begin
                            r_base  <= w_prod;
                            r_state <= ST_MUL;
                        end else if (r_state == ST_MUL) begin
                            if (r_dkey[r_bit])
                                r_result <= w_prod;
                            r_state <= ST_SQR;
                        end else begin
                            r_base <= w_prod;
                            if (r_bit == LAST) begin
                                r_plain <= r_result;
                                r_state <= ST_DONE;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_state <= ST_MUL;
                            end
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign plain = r_plain;
    assign err   = r_err;
    assign done  = (r_state == ST_DONE);
    assign busy  = (r_state == ST_RED) || (r_state == ST_MUL) || (r_state == ST_SQR);

endmodule

// File: tb/tb_rsa_decoder.sv
// Directed and randomized checks of rsa_decoder against a repeated-multiplication
// reference for c^d mod n, including latency, busy/done timing and reset abort.
module tb_rsa_decoder;

    localparam int W   = 8;
    localparam int LAT = 1 + W + 2 * W * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] cipher;
    logic [W-1:0] d_key;
    logic [W-1:0] n_mod;
    logic [W-1:0] plain;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    rsa_decoder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cipher (cipher),
        .d_key  (d_key),
        .n_mod  (n_mod),
        .plain  (plain),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic int unsigned ref_modexp(input int unsigned c, input int unsigned d,
                                               input int unsigned n);
        longint unsigned m;
        if (n < 2) return 0;
        m = 1 % n;
        for (int i = 0; i < int'(d); i++) m = (m * c) % n;
        return int'(m);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_decode(input logic [W-1:0] c, input logic [W-1:0] d,
                              input logic [W-1:0] n, input bit inject);
        int unsigned exp_plain;
        bit          exp_err;
        int          exp_lat;
        int          cyc;
        bit          seen;
        bit          busy_bad;
        bit          extra;
        logic [W-1:0] held;
        exp_err   = (n < 2);
        exp_plain = ref_modexp(c, d, n);
        exp_lat   = exp_err ? 1 : LAT;

        @(negedge clk);
        cipher = c; d_key = d; n_mod = n; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cipher = W'($urandom); d_key = W'($urandom); n_mod = W'($urandom);
        cyc = 1; seen = 0; busy_bad = 0;
        while (cyc <= LAT + 20) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy !== !exp_err) busy_bad = 1;
            if (inject && cyc == 39) start = 1'b1;
            if (inject && cyc == 40) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'(exp_lat));
        check("busy_during", 32'(busy_bad), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
        check("plain", 32'(plain), exp_plain);
        check("err", 32'(err), 32'(exp_err));
        held = plain;

        if (inject) start = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done !== 1'b0 || busy !== 1'b0) extra = 1;
        end
        check("no_extra_done", 32'(extra), 32'd0);
        check("plain_hold", 32'(plain), 32'(held));
        check("err_hold", 32'(err), 32'(exp_err));
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; cipher = '0; d_key = '0; n_mod = '0;
        repeat (3) @(negedge clk);
        check("rst_plain", 32'(plain), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_decode(8'd13, 8'd3, 8'd15, 0);
        run_decode(8'd31, 8'd7, 8'd33, 0);
        run_decode(8'd200, 8'd1, 8'd33, 0);
        run_decode(8'd31, 8'd0, 8'd33, 0);
        run_decode(8'd5, 8'd3, 8'd1, 0);
        run_decode(8'd9, 8'd4, 8'd0, 0);
        run_decode(8'd0, 8'd5, 8'd77, 0);
        run_decode(8'd255, 8'd255, 8'd255, 0);
        run_decode(8'd254, 8'd255, 8'd2, 0);
        run_decode(8'd13, 8'd3, 8'd15, 1);
        run_decode(8'd123, 8'd45, 8'd251, 1);

        @(negedge clk);
        cipher = 8'd13; d_key = 8'd3; n_mod = 8'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_plain", 32'(plain), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        rst = 1'b0; start = 1'b0;
        saw_done = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
        end
        check("abort_no_activity", 32'(saw_done), 32'd0);
        run_decode(8'd13, 8'd3, 8'd15, 0);

        for (int k = 0; k < 25; k++) begin
            run_decode(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                       W'($urandom_range(2, 255)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
